// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchroniser, mid-bit
// sampling, stop-bit checking and a one-cycle valid strobe per byte.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
`endif

  // Two-flop synchroniser, preset high so reset looks like an idle line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (!rx_sync) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            par_bad <= (^shreg) ^ rx_sync;
            state   <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif

        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
              if (!par_bad) begin
                data_out <= shreg;
                valid    <= 1'b1;
              end
`else
              data_out <= shreg;
              valid    <= 1'b1;
`endif
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        BREAK: begin
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
module tb_uart_rx;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME = 11 * BIT;
  localparam int LAT   = 2 + BIT / 2 + 10 * BIT + 1;
`else
  localparam int FRAME = 10 * BIT;
  localparam int LAT   = 2 + BIT / 2 + 9 * BIT + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int valid_count = 0;
  int frame_err_count = 0;
  int parity_err_count = 0;
  int both_count = 0;
  logic [7:0] captured [0:15];
  int valid_cycle [0:15];

  uart_rx #(.CLKS_PER_BIT(BIT)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .valid(valid),
    .busy(busy),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter: value equals the index of the last rising edge
  always @(posedge clk) cycle++;

  // Strobe monitor sampled on the falling edge
  always @(negedge clk) begin
    if (valid) begin
      valid_count++;
      if (valid_count < 16) begin
        captured[valid_count]    = data_out;
        valid_cycle[valid_count] = cycle;
      end
    end
    if (frame_err) frame_err_count++;
    if (parity_err) parity_err_count++;
    if (valid && frame_err) both_count++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop_bit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(par);
`else
    if (par !== par) driveBit(1'b1);
`endif
    driveBit(stop_bit);
  endtask

  initial begin
    int v0;
    int f0;
    int start_cycle;
    int diff;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_data_out", int'(data_out), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_parity_err", int'(parity_err), 0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("idle_no_valid", valid_count, 0);
    checkOutput("idle_no_frame_err", frame_err_count, 0);
    checkOutput("idle_busy", int'(busy), 0);

    $display("[TB] single frame 0xAA");
    start_cycle = cycle + 1;
    applyStimulus(8'hAA, 1'b0, 1'b1);
    checkOutput("aa_valid_count", valid_count, 1);
    checkOutput("aa_data", int'(captured[1]), 8'hAA);
    checkOutput("aa_frame_err", frame_err_count, 0);
    checkOutput("aa_busy_after", int'(busy), 0);
    diff = valid_cycle[1] - (start_cycle + LAT);
    checkOutput("aa_latency_in_tol", int'(diff >= -2 && diff <= 2), 1);
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] back-to-back 0x55 then 0xFF");
    applyStimulus(8'h55, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("b2b_valid_count", valid_count, 3);
    checkOutput("b2b_first", int'(captured[2]), 8'h55);
    checkOutput("b2b_second", int'(captured[3]), 8'hFF);
    checkOutput("b2b_spacing", valid_cycle[3] - valid_cycle[2], FRAME);

    $display("[TB] short start glitch");
    v0 = valid_count;
    f0 = frame_err_count;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    checkOutput("glitch_busy_rise", int'(busy), 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("glitch_busy_fall", int'(busy), 0);
    checkOutput("glitch_no_valid", valid_count, v0);
    checkOutput("glitch_no_frame_err", frame_err_count, f0);

    $display("[TB] framing error 0x3C then break");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("ferr_count", frame_err_count, f0 + 1);
    checkOutput("ferr_no_valid", valid_count, v0);
    checkOutput("ferr_data_held", int'(data_out), 8'hFF);
    checkOutput("break_busy_high", int'(busy), 1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("break_busy_release", int'(busy), 0);
    repeat (20) @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity good and bad");
    v0 = valid_count;
    applyStimulus(8'h01, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("par_good_valid", valid_count, v0 + 1);
    checkOutput("par_good_data", int'(data_out), 8'h01);
    checkOutput("par_good_no_err", parity_err_count, 0);
    applyStimulus(8'h01, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("par_bad_err", parity_err_count, 1);
    checkOutput("par_bad_no_valid", valid_count, v0 + 1);
    repeat (20) @(posedge clk);
    #1;
`endif

    $display("[TB] reset during data bits");
    v0 = valid_count;
    f0 = frame_err_count;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    checkOutput("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_data", int'(data_out), 0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("mid_rst_no_valid", valid_count, v0);
    checkOutput("mid_rst_no_frame_err", frame_err_count, f0);
    checkOutput("mid_rst_busy_idle", int'(busy), 0);

`ifndef UART_RX_PARITY_EN
    checkOutput("no_parity_err_ever", parity_err_count, 0);
`endif
    checkOutput("valid_frame_err_exclusive", both_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
